reaction_ctrl: RTL and testbench
================================

// Module: reaction_ctrl
// PURPOSE
//  Game sequencer for the reaction-timer datapath. Drives load_rand into the random-delay
//  generator, watches its go LED, and times the player's response in milliseconds.
//  Flags false starts and timeouts, and reports the result to the display logic.
// PARAMETERS
//  CNT_W       10   width of the millisecond counter and of the result outputs
//  TIMEOUT_MS  999  GO-phase limit in ms; must be < 2**CNT_W
// PORTS
//  clk           in   1      system clock
//  reset         in   1      synchronous, active-low reset
//  start_btn     in   1      debounced level; rising edge starts or restarts a round
//  react_btn     in   1      debounced level; rising edge is the player's response
//  tick_ms       in   1      one-clk strobe at 1 kHz
//  go_led        in   1      lit indicator from the delay generator (delay has expired)
//  load_rand     out  1      to the delay generator; high = hold/reload the random delay
//  busy          out  1      high in ARM, WAIT and GO
//  result_ms     out  CNT_W  latched reaction time
//  result_valid  out  1      high in DONE while result_ms is meaningful
//  foul          out  1      false start: react pressed before go_led
//  timeout       out  1      no react within TIMEOUT_MS
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge) wins over everything. Resulting state:
//    IDLE, load_rand=1, busy=0, result_ms=0, result_valid=0, foul=0, timeout=0,
//    edge-detect registers=0. Reset mid-round aborts the round with no result.
//  - Edge detect: registered previous value of each button. A press is seen one clk after
//    the level rises. A held button produces exactly one press.
//  - FSM is one-hot or binary (implementer's choice). Encodings come from the package.
//    IDLE : load_rand=1. start press -> ARM.
//    ARM  : load_rand=1 for exactly one clk; clear result_ms, foul, timeout. Next -> WAIT.
//    WAIT : load_rand=0 (delay runs). react press -> FOUL. Else go_led=1 -> GO with ms_cnt=0.
//           react press and go_led in the same clk -> FOUL (early wins).
//    GO   : each tick_ms increments ms_cnt.
//           react press -> DONE, result_ms=ms_cnt (the tick in that clk is not counted).
//           ms_cnt==TIMEOUT_MS and no press -> DONE, timeout=1, result_ms=TIMEOUT_MS.
//    DONE : load_rand=1, result_valid=1. start press -> ARM. react presses are ignored.
//    FOUL : load_rand=1, foul=1, result_ms=0. start press -> ARM.
//  - start press in WAIT or GO aborts the round -> ARM (restart). It beats react in the same clk.
//  - ms_cnt saturates at TIMEOUT_MS and never wraps. All outputs are registered.
// CONFIGURATION
//  BEST_TIME_EN defined: adds output best_ms[CNT_W-1:0].
//    - Reset value is all-ones.
//    - On entry to DONE with timeout=0 and result_ms<best_ms, best_ms is updated one clk later.
//    - FOUL and timeout rounds never update it.
//  BEST_TIME_EN undefined: the port and register are absent; behaviour is otherwise identical.
// STRUCTURE
//  - Shared header reaction_pkg.vh: state encodings (ST_IDLE..ST_FOUL), the CNT_W default,
//    and the TIMEOUT_MS default.
//  - One sub-module, btn_edge (1-bit registered rising-edge detector), is instantiated twice.
//  - The FSM and ms counter stay in reaction_ctrl.
// TESTING
//  1. Reset, then start press -> load_rand is 1 for one clk in ARM, then 0.
//     Drive go_led, then react after 237 ticks -> result_ms=237, result_valid=1, load_rand=1.
//  2. start, then react press while go_led=0 -> FOUL, foul=1, result_ms=0, busy=0.
//     Next start -> foul clears.
//  3. go_led and react edge in the same clk -> FOUL. In GO, react and tick_ms in the same clk
//     -> that tick is not counted.
//  4. GO with no react -> after 999 ticks: timeout=1, result_ms=999. Further ticks do not change it.
//  5. Assert reset mid-GO -> next clk all outputs at reset values. Restart from start works.
//  6. BEST_TIME_EN: rounds of 300, 150, foul, 200 -> best_ms = 300, 150, 150, 150.
//     Without the macro the design compiles with no best_ms port.

Source files
------------

// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer sequencer: state encodings and
// default sizing for the millisecond counter and the GO-phase limit.
package reaction_pkg;

  localparam int CNT_W_DEF      = 10;
  localparam int TIMEOUT_MS_DEF = 999;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_WAIT = 3'd2,
    ST_GO   = 3'd3,
    ST_DONE = 3'd4,
    ST_FOUL = 3'd5
  } state_t;

endpackage

// File: rtl/btn_edge.sv
// 1-bit rising-edge detector. The previous level is registered; a press is
// reported while the level is high and the previous level was low, so a held
// button yields exactly one press.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic prev;

  // remember last sampled level; cleared by reset so a button held through reset yields one press
  always_ff @(posedge clk) begin
    if (!reset) prev <= 1'b0;
    else        prev <= btn;
  end

  assign press = btn & ~prev;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer game sequencer. Drives load_rand into the random-delay
// generator, waits for its go LED and times the player's response in ms.
// Optional feature macro: BEST_TIME_EN adds the best_ms output/register.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int TIMEOUT_MS = TIMEOUT_MS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_btn,
  input  logic             react_btn,
  input  logic             tick_ms,
  input  logic             go_led,
  output logic             load_rand,
  output logic             busy,
  output logic [CNT_W-1:0] result_ms,
  output logic             result_valid,
  output logic             foul,
  output logic             timeout
`ifdef BEST_TIME_EN
  ,output logic [CNT_W-1:0] best_ms
`endif
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_MS);

  state_t           state;
  logic [CNT_W-1:0] ms_cnt;
  logic [1:0]       btn_lvl, btn_press;
  logic             start_p, react_p, arm_req;

  // bit 0 = start, bit 1 = react
  assign btn_lvl = {react_btn, start_btn};

  btn_edge u_edge [1:0] (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_lvl),
    .press (btn_press)
  );

  assign start_p = btn_press[0];
  assign react_p = btn_press[1];

  // a start press (re)arms from every state except ARM itself; it beats react
  assign arm_req = start_p && (state != ST_ARM);

  // round sequencer with registered outputs; ms_cnt only advances in GO and saturates at TMO
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      load_rand    <= 1'b1;
      busy         <= 1'b0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
      ms_cnt       <= '0;
    end else if (arm_req) begin
      state        <= ST_ARM;
      load_rand    <= 1'b1;
      busy         <= 1'b1;
      result_ms    <= '0;
      result_valid <= 1'b0;
      foul         <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      case (state)
        ST_ARM: begin
          state     <= ST_WAIT;
          load_rand <= 1'b0;
        end
        ST_WAIT: begin
          if (react_p) begin
            state     <= ST_FOUL;
            load_rand <= 1'b1;
            busy      <= 1'b0;
            foul      <= 1'b1;
            result_ms <= '0;
          end else if (go_led) begin
            state  <= ST_GO;
            ms_cnt <= '0;
          end
        end
        ST_GO: begin
          if (react_p) begin
            // a tick arriving with the press is deliberately not counted
            state        <= ST_DONE;
            result_ms    <= ms_cnt;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            load_rand    <= 1'b1;
          end else if (ms_cnt == TMO) begin
            state        <= ST_DONE;
            timeout      <= 1'b1;
            result_ms    <= TMO;
            result_valid <= 1'b1;
            busy         <= 1'b0;
            load_rand    <= 1'b1;
          end else if (tick_ms) begin
            ms_cnt <= ms_cnt + 1'b1;
          end
        end
        ST_IDLE, ST_DONE, ST_FOUL: ;
        default: begin
          state     <= ST_IDLE;
          load_rand <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef BEST_TIME_EN
  // track the fastest valid reaction; lands one clk after DONE is entered
  always_ff @(posedge clk) begin
    if (!reset)
      best_ms <= '1;
    else if (state == ST_DONE && !timeout && result_ms < best_ms)
      best_ms <= result_ms;
  end
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Randomized self-checking bench for reaction_ctrl. Expected results come from
// round-level rules (reaction = ticks seen before the press, foul if pressed
// before go, timeout at the limit, best = minimum of clean rounds).
module tb_reaction_ctrl;

  localparam int CNT_W = 10;
  localparam int TMO   = 999;
  localparam int ONES  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, start_btn, react_btn, tick_ms, go_led;
  logic             load_rand, busy, result_valid, foul, timeout;
  logic [CNT_W-1:0] result_ms;
`ifdef BEST_TIME_EN
  logic [CNT_W-1:0] best_ms;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int best_m  = ONES;

  reaction_ctrl #(.CNT_W(CNT_W), .TIMEOUT_MS(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_btn    (start_btn),
    .react_btn    (react_btn),
    .tick_ms      (tick_ms),
    .go_led       (go_led),
    .load_rand    (load_rand),
    .busy         (busy),
    .result_ms    (result_ms),
    .result_valid (result_valid),
    .foul         (foul),
    .timeout      (timeout)
`ifdef BEST_TIME_EN
    ,.best_ms     (best_ms)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_ms = 1'b1; cyc(1);
      tick_ms = 1'b0; cyc(1);
    end
  endtask

  task automatic check_best(input string tag);
`ifdef BEST_TIME_EN
    chk(tag, best_ms, best_m);
`endif
  endtask

  // start press from a resting state; returns in ARM
  task automatic press_start();
    go_led = 1'b0;
    start_btn = 1'b1; cyc(1);
    start_btn = 1'b0;
    chk("arm_load", load_rand, 1);
    chk("arm_busy", busy, 1);
    chk("arm_res", result_ms, 0);
    chk("arm_flags", {result_valid, foul, timeout}, 0);
    cyc(1);
    chk("wait_load", load_rand, 0);
  endtask

  // clean round: d idle clks in WAIT, go, n ticks, react; optional restart after k ticks
  task automatic round_good(input int d, input int n, input bit tick_with, input int k);
    press_start();
    cyc(d);
    go_led = 1'b1; cyc(1);
    if (k >= 0) begin
      ticks(k);
      go_led = 1'b0;
      react_btn = $urandom_range(0, 1);
      start_btn = 1'b1; cyc(1);
      start_btn = 1'b0; react_btn = 1'b0;
      chk("rst_arm_busy", busy, 1);
      chk("rst_arm_res", result_ms, 0);
      chk("rst_arm_foul", foul, 0);
      cyc(1);
      go_led = 1'b1; cyc(1);
    end
    ticks(n);
    react_btn = 1'b1; tick_ms = tick_with; cyc(1);
    react_btn = 1'b0; tick_ms = 1'b0;
    chk("done_res", result_ms, n);
    chk("done_valid", result_valid, 1);
    chk("done_busy", busy, 0);
    chk("done_load", load_rand, 1);
    chk("done_flags", {foul, timeout}, 0);
    check_best("best_hold");
    if (n < best_m) best_m = n;
    cyc(1);
    check_best("best_upd");
    // react again in DONE: ignored
    react_btn = 1'b1; cyc(1); react_btn = 1'b0; cyc(1);
    chk("done_react_ign", result_ms, n);
    go_led = 1'b0;
  endtask

  // false start: react while go low, or together with go (early wins)
  task automatic round_foul(input int d, input bit with_go);
    press_start();
    cyc(d);
    react_btn = 1'b1; go_led = with_go; cyc(1);
    react_btn = 1'b0; go_led = 1'b0;
    chk("foul_flag", foul, 1);
    chk("foul_res", result_ms, 0);
    chk("foul_busy", busy, 0);
    chk("foul_valid", result_valid, 0);
    chk("foul_load", load_rand, 1);
    cyc(2);
    check_best("foul_best");
  endtask

  task automatic round_timeout();
    press_start();
    go_led = 1'b1; cyc(1);
    ticks(TMO);
    chk("tmo_flag", timeout, 1);
    chk("tmo_res", result_ms, TMO);
    chk("tmo_valid", result_valid, 1);
    chk("tmo_busy", busy, 0);
    ticks(5);
    react_btn = 1'b1; cyc(1); react_btn = 1'b0; cyc(1);
    chk("tmo_sat", result_ms, TMO);
    chk("tmo_flag2", timeout, 1);
    check_best("tmo_best");
    go_led = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_load"}, load_rand, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res"}, result_ms, 0);
    chk({tag, "_flags"}, {result_valid, foul, timeout}, 0);
    check_best({tag, "_best"});
  endtask

  initial begin
    int tmo_cnt = 0;
    reset = 1'b0; start_btn = 1'b0; react_btn = 1'b0; tick_ms = 1'b0; go_led = 1'b0;
    cyc(3);
    check_reset_state("reset");
    reset = 1'b1; cyc(2);
    check_reset_state("idle");

    // best-time sequence 300, 150, foul, 200
    round_good(3, 300, 1'b0, -1);
    round_good(1, 150, 1'b1, -1);
    round_foul(2, 1'b0);
    round_good(0, 200, 1'b0, -1);

    // the first reaction example plus boundaries
    round_good(4, 237, 1'b0, -1);
    round_foul(0, 1'b1);
    round_good(2, 0, 1'b1, -1);
    round_good(1, 998, 1'b0, -1);
    round_timeout();

    // held start: only one arm
    go_led = 1'b0;
    start_btn = 1'b1; cyc(4);
    chk("held_busy", busy, 1);
    chk("held_load", load_rand, 0);
    start_btn = 1'b0;
    react_btn = 1'b1; cyc(1); react_btn = 1'b0;
    chk("held_foul", foul, 1);

    // reset mid-GO aborts the round
    press_start();
    go_led = 1'b1; cyc(1);
    ticks(40);
    reset = 1'b0; cyc(1);
    best_m = ONES;
    check_reset_state("midgo");
    reset = 1'b1; go_led = 1'b0; cyc(1);
    round_good(2, 77, 1'b0, -1);

    // randomized rounds
    for (int r = 0; r < 20; r++) begin
      int mode = $urandom_range(0, 5);
      int d    = $urandom_range(0, 6);
      int n    = $urandom_range(0, 400);
      case (mode)
        0, 1: round_good(d, n, 1'($urandom_range(0, 1)), -1);
        2:    round_foul(d, 1'b0);
        3:    round_foul(d, 1'b1);
        4:    round_good(d, n, 1'($urandom_range(0, 1)), $urandom_range(0, 50));
        default: begin
          if (tmo_cnt < 2) begin
            tmo_cnt++;
            round_timeout();
          end else begin
            round_good(d, n, 1'b0, -1);
          end
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
